// File: rtl/gf_inv_iter.sv
`default_nettype none
// ============================================================================
// Module   : gf_inv_iter
// Purpose  : Sequential GF(2^WIDTH) inverter, inv(a) = a^(2^WIDTH-2), via one
//            square and one multiply per cycle with valid/ready handshakes.
// Revision : 1.0
// ============================================================================
module gf_inv_iter #(
    parameter int                 WIDTH = 4,
    parameter logic [WIDTH:0]     POLY  = 5'b10011
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             busy
);

    localparam int CW = (WIDTH <= 2) ? 1 : $clog2(WIDTH);

    if (WIDTH < 2 || WIDTH > 16 || POLY[WIDTH] != 1'b1 || POLY[0] != 1'b1) begin : g_bad_param
        $fatal(1, "gf_inv_iter: illegal WIDTH or POLY");
    end

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state, state_n;
    logic [WIDTH-1:0] sq, acc;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] sq_n, prod;
    logic             last;

    // Shift-and-reduce product: t walks through a*x^i mod POLY.
    function automatic logic [WIDTH-1:0] gf_mul(input logic [WIDTH-1:0] a,
                                                input logic [WIDTH-1:0] b);
        logic [WIDTH-1:0] p;
        logic [WIDTH-1:0] t;
        p = '0;
        t = a;
        for (int i = 0; i < WIDTH; i++) begin
            if (b[i]) p = p ^ t;
            if (t[WIDTH-1]) t = {t[WIDTH-2:0], 1'b0} ^ POLY[WIDTH-1:0];
            else            t = {t[WIDTH-2:0], 1'b0};
        end
        return p;
    endfunction

    assign sq_n = gf_mul(sq, sq);
    assign prod = gf_mul(acc, sq_n);
    assign last = (cnt == CW'(WIDTH - 2));

    always_comb begin
        state_n   = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_n = CALC;
            end
            CALC: begin
                busy = 1'b1;
                if (last) state_n = DONE;
            end
            DONE: begin
                busy      = 1'b1;
                out_valid = 1'b1;
                if (out_ready) state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    // acc collects a^2 * a^4 * ... * a^(2^(WIDTH-1)) over WIDTH-1 CALC cycles.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            sq       <= '0;
            acc      <= '0;
            cnt      <= '0;
            out_data <= '0;
        end else begin
            state <= state_n;
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        sq  <= in_data;
                        acc <= {{(WIDTH-1){1'b0}}, 1'b1};
                        cnt <= '0;
                    end
                end
                CALC: begin
                    sq  <= sq_n;
                    acc <= prod;
                    if (last) begin
                        cnt      <= '0;
                        out_data <= prod;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_gf_inv_iter.sv
`default_nettype none
// ============================================================================
// Module   : tb_gf_inv_iter
// Purpose  : Self-checking bench for gf_inv_iter at WIDTH=4 and WIDTH=8.
// Revision : 1.0
// ============================================================================
module tb_gf_inv_iter;

    logic       clk;
    logic       rst_n;
    logic       sel;          // 0 drives the WIDTH=4 instance, 1 the WIDTH=8 one
    logic       in_valid;
    logic       out_ready;
    logic [7:0] in_data;

    logic       in_ready4, out_valid4, busy4;
    logic [3:0] out_data4;
    logic       in_ready8, out_valid8, busy8;
    logic [7:0] out_data8;

    logic       in_ready_m, out_valid_m, busy_m;
    logic [7:0] out_data_m;

    int n_checks;
    int n_errors;
    int inv4[16];
    int inv8[256];

    gf_inv_iter #(.WIDTH(4), .POLY(5'b10011)) u_dut4 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid & ~sel),
        .in_ready  (in_ready4),
        .in_data   (in_data[3:0]),
        .out_valid (out_valid4),
        .out_ready (out_ready & ~sel),
        .out_data  (out_data4),
        .busy      (busy4)
    );

    gf_inv_iter #(.WIDTH(8), .POLY(9'h11B)) u_dut8 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid & sel),
        .in_ready  (in_ready8),
        .in_data   (in_data),
        .out_valid (out_valid8),
        .out_ready (out_ready & sel),
        .out_data  (out_data8),
        .busy      (busy8)
    );

    assign in_ready_m  = sel ? in_ready8  : in_ready4;
    assign out_valid_m = sel ? out_valid8 : out_valid4;
    assign busy_m      = sel ? busy8      : busy4;
    assign out_data_m  = sel ? out_data8  : {4'h0, out_data4};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #800000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference: full carry-less product, then polynomial long division.
    function automatic int ref_mul(input int a, input int b, input int poly, input int w);
        int p;
        p = 0;
        for (int i = 0; i < w; i++)
            if (((b >> i) & 1) != 0) p = p ^ (a << i);
        for (int i = 2 * w - 2; i >= w; i--)
            if (((p >> i) & 1) != 0) p = p ^ (poly << (i - w));
        return p & ((1 << w) - 1);
    endfunction

    task automatic do_op(input int a, output int res, output int lat, output int bcnt);
        int guard;
        in_data   = 8'(a);
        in_valid  = 1'b1;
        out_ready = 1'b1;
        guard = 0;
        while (!in_ready_m && guard < 50) begin
            @(posedge clk); #1;
            guard++;
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat  = 0;
        bcnt = busy_m ? 1 : 0;
        while (!out_valid_m && lat < 50) begin
            @(posedge clk); #1;
            lat++;
            if (busy_m) bcnt++;
        end
        res = int'(out_data_m);
        if (!out_valid_m) check("op_timeout", 0, 1);
        @(posedge clk); #1;
        if (busy_m) bcnt++;
        out_ready = 1'b0;
    endtask

    task automatic run_random(input bit s, input int n);
        int  sent, got, cyc;
        int  exp_q[$];
        bit  accepted;
        sel = s;
        sent = 0; got = 0; cyc = 0;
        in_valid = 1'b0;
        out_ready = 1'b0;
        @(posedge clk); #1;
        while (got < n && cyc < n * 40) begin
            if (!in_valid && sent < n && $urandom_range(0, 3) != 0) begin
                in_data  = s ? 8'($urandom_range(0, 255)) : 8'($urandom_range(0, 15));
                in_valid = 1'b1;
            end
            out_ready = 1'($urandom_range(0, 1));
            @(negedge clk);
            accepted = in_valid && in_ready_m;
            if (accepted) begin
                exp_q.push_back(s ? inv8[in_data] : inv4[in_data[3:0]]);
                sent++;
            end
            if (out_valid_m && out_ready) begin
                if (exp_q.size() == 0) check(s ? "rand8_dup" : "rand4_dup", 1, 0);
                else check(s ? "rand8" : "rand4", int'(out_data_m), exp_q.pop_front());
                got++;
            end
            @(posedge clk); #1;
            if (accepted) in_valid = 1'b0;
            cyc++;
        end
        in_valid  = 1'b0;
        out_ready = 1'b0;
        check(s ? "rand8_count" : "rand4_count", got, n);
        check(s ? "rand8_left" : "rand4_left", exp_q.size(), 0);
    endtask

    initial begin
        int res, lat, bcnt, guard;
        n_checks = 0;
        n_errors = 0;
        for (int a = 0; a < 16; a++) begin
            inv4[a] = 0;
            for (int b = 1; b < 16; b++) if (ref_mul(a, b, 'h13, 4) == 1) inv4[a] = b;
        end
        for (int a = 0; a < 256; a++) begin
            inv8[a] = 0;
            for (int b = 1; b < 256; b++) if (ref_mul(a, b, 'h11B, 8) == 1) inv8[a] = b;
        end

        sel = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_data = '0;
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        #1;
        check("rst_out_valid", {out_valid4, out_valid8}, 0);
        check("rst_out_data", {out_data4, out_data8}, 0);
        check("rst_in_ready", {in_ready4, in_ready8}, 2'b11);
        check("rst_busy", {busy4, busy8}, 0);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;

        // Directed WIDTH=4 vectors
        do_op(2, res, lat, bcnt);
        check("w4_inv2", res, 9);
        check("w4_lat", lat, 3);
        do_op(1, res, lat, bcnt);
        check("w4_inv1", res, 1);
        do_op(0, res, lat, bcnt);
        check("w4_inv0", res, 0);
        check("w4_lat0", lat, 3);

        for (int a = 1; a < 16; a++) begin
            do_op(a, res, lat, bcnt);
            check("w4_prod", ref_mul(a, res, 'h13, 4), 1);
            check("w4_busy", bcnt, 4);
        end

        sel = 1'b1;
        @(posedge clk); #1;
        do_op('h53, res, lat, bcnt);
        check("w8_inv53", res, 'hCA);
        check("w8_lat", lat, 7);
        for (int a = 1; a < 256; a++) begin
            do_op(a, res, lat, bcnt);
            check("w8_prod", ref_mul(a, res, 'h11B, 8), 1);
        end

        // Backpressure on WIDTH=4
        sel = 1'b0;
        @(posedge clk); #1;
        in_data = 8'h5; in_valid = 1'b1; out_ready = 1'b0;
        @(posedge clk); #1;
        in_data = 8'h7;
        guard = 0;
        while (!out_valid_m && guard < 20) begin
            @(posedge clk); #1;
            check("bp_in_ready_calc", in_ready_m, 0);
            guard++;
        end
        check("bp_valid", out_valid_m, 1);
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            check("bp_hold_valid", out_valid_m, 1);
            check("bp_hold_data", int'(out_data_m), inv4[5]);
            check("bp_in_ready", in_ready_m, 0);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        check("bp_release", out_valid_m, 0);
        check("bp_idle_ready", in_ready_m, 1);
        out_ready = 1'b0;
        @(posedge clk); #1;
        check("bp_accept", {busy_m, in_ready_m}, 2'b10);
        in_valid = 1'b0;
        guard = 0;
        while (!out_valid_m && guard < 20) begin
            @(posedge clk); #1;
            guard++;
        end
        check("bp_second", int'(out_data_m), inv4[7]);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;

        // Asynchronous reset during CALC on WIDTH=8
        sel = 1'b1;
        @(posedge clk); #1;
        in_data = 8'h53; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("mid_busy", busy_m, 1);
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_valid", out_valid_m, 0);
        check("mid_rst_data", int'(out_data_m), 0);
        check("mid_rst_ready", in_ready_m, 1);
        @(posedge clk); #1 rst_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            check("mid_no_pulse", out_valid_m, 0);
        end
        do_op(2, res, lat, bcnt);
        check("post_rst_inv2", res, 'h8D);

        run_random(1'b0, 1000);
        run_random(1'b1, 1000);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
